// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared constants and types for the PC / fetch-queue front end: default
// reset PC and redirect vectors, kernel-bit position, the nop encoding and the
// redirect-cause enumeration used by the next-PC priority mux.
// Ports: none (package).
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned KBIT     = XLEN_DEF - 1;

  localparam logic [XLEN_DEF-1:0] RESET_PC_DEF = 32'h0000_0004;
  localparam logic [XLEN_DEF-1:0] EXC_VEC_DEF  = 32'h8000_0008;
  localparam logic [XLEN_DEF-1:0] IRQ_VEC_DEF  = 32'h8000_0004;

  localparam logic [31:0] NOP = 32'h0000_0000;

  // Which source, if any, steers the PC this cycle (highest priority first).
  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_EXC  = 2'd1,
    CAUSE_IRQ  = 2'd2,
    CAUSE_BR   = 2'd3
  } redir_cause_t;

endpackage

// File: rtl/pc_fetch_queue_if.sv
// -----------------------------------------------------------------------------
// pc_fetch_queue_if
// Bundles the instruction-memory port, redirect inputs and the decode-side
// valid/ready handshake of pc_fetch_queue.
//   master : the fetch unit (drives if_pc, id_*, fq_count, kernel)
//   slave  : the surroundings (imem data, redirects, decode ready)
// -----------------------------------------------------------------------------
interface pc_fetch_queue_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]  if_pc;
  logic [31:0]      if_inst;
  logic             exc_req;
  logic             irq_req;
  logic             redir_valid;
  logic [XLEN-1:0]  redir_pc;
  logic             redir_user;
  logic             id_ready;
  logic             id_valid;
  logic [31:0]      id_inst;
  logic [XLEN-1:0]  id_pc4;
  logic [CNT_W-1:0] fq_count;
  logic             kernel;

  modport master (
    output if_pc, id_valid, id_inst, id_pc4, fq_count, kernel,
    input  if_inst, exc_req, irq_req, redir_valid, redir_pc, redir_user, id_ready
  );

  modport slave (
    input  if_pc, id_valid, id_inst, id_pc4, fq_count, kernel,
    output if_inst, exc_req, irq_req, redir_valid, redir_pc, redir_user, id_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// DEPTH-entry circular buffer of W-bit words with push, pop and flush.
//   clk, reset : clock, synchronous active-high reset
//   i_flush    : drop all entries (wins over push/pop)
//   i_push     : enqueue i_wdata (accepted when not full or popping)
//   i_pop      : dequeue head (ignored when empty)
//   o_rdata    : current head entry
//   o_count    : occupancy, 0..DEPTH
//   o_empty    : occupancy is zero
//   o_full     : occupancy equals DEPTH
// -----------------------------------------------------------------------------
module fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [W-1:0]           i_wdata,
  output logic [W-1:0]           o_rdata,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty,
  output logic                   o_full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));

  // A full queue still accepts a push when the head leaves in the same cycle.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Pointers and occupancy; power-of-two depth makes the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (!reset && !i_flush && w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/pc_fetch_queue.sv
// -----------------------------------------------------------------------------
// pc_fetch_queue
// Fetch PC generator plus a DEPTH-entry instruction queue feeding decode over
// a valid/ready handshake. Exception, interrupt and branch/jump redirects
// flush the queue; the kernel bit (PC[XLEN-1]) is carried across sequential
// fetch and branch redirects.
//   clk, reset : clock, synchronous active-high reset
//   bus        : pc_fetch_queue_if.master
//                if_pc/if_inst   combinational imem read
//                exc_req, irq_req, redir_valid/redir_pc/redir_user  redirects
//                id_ready/id_valid/id_inst/id_pc4  decode handshake
//                fq_count        queue occupancy
//                kernel          if_pc[XLEN-1]
// Build option: FQ_BYPASS_EN -- when the queue is empty, a fetched word goes
// straight into the ID registers (1-cycle fetch-to-decode); otherwise every
// word passes through the queue (2 cycles).
// -----------------------------------------------------------------------------
module pc_fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     IDX_W    = 8,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
  parameter logic [XLEN-1:0] EXC_VEC  = XLEN'(EXC_VEC_DEF),
  parameter logic [XLEN-1:0] IRQ_VEC  = XLEN'(IRQ_VEC_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  pc_fetch_queue_if.master  bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned QW    = 32 + XLEN;

`ifdef FQ_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [XLEN-1:0]  r_pc;
  logic             r_id_valid;
  logic [31:0]      r_id_inst;
  logic [XLEN-1:0]  r_id_pc4;

  logic [XLEN-1:0]  w_pc_nxt;
  logic             w_id_valid_nxt;
  logic [31:0]      w_id_inst_nxt;
  logic [XLEN-1:0]  w_id_pc4_nxt;

  logic             w_kernel;
  logic             w_irq_take;
  redir_cause_t     w_cause;
  logic [XLEN-1:0]  w_redir_tgt;
  logic [IDX_W-1:0] w_idx_inc;
  logic [XLEN-1:0]  w_pc4;

  logic             w_pop;
  logic             w_push;
  logic             w_bypass;
  logic             w_q_push;
  logic             w_q_pop;
  logic             w_q_flush;
  logic [QW-1:0]    w_q_rdata;
  logic [CNT_W-1:0] w_q_count;
  logic             w_q_empty;
  logic             w_q_full;

  assign w_kernel   = r_pc[XLEN-1];
  assign w_irq_take = bus.irq_req & ~w_kernel;

  // Sequential successor: only the instruction index advances, wrapping in place.
  assign w_idx_inc = r_pc[IDX_W+1:2] + IDX_W'(1);
  assign w_pc4     = {r_pc[XLEN-1:IDX_W+2], w_idx_inc, r_pc[1:0]};

  // Redirect cause, exception first.
  always_comb begin
    w_cause = CAUSE_NONE;
    if (bus.exc_req)          w_cause = CAUSE_EXC;
    else if (w_irq_take)      w_cause = CAUSE_IRQ;
    else if (bus.redir_valid) w_cause = CAUSE_BR;
  end

  // Redirect target; branches keep the current kernel bit unless told to drop it.
  always_comb begin
    w_redir_tgt = {(bus.redir_user ? 1'b0 : w_kernel), bus.redir_pc[XLEN-2:0]};
    case (w_cause)
      CAUSE_EXC: w_redir_tgt = EXC_VEC;
      CAUSE_IRQ: w_redir_tgt = IRQ_VEC;
      default:   ;
    endcase
  end

  // Handshake terms for the no-redirect case.
  assign w_pop    = bus.id_ready | ~r_id_valid;
  assign w_push   = (w_q_count < CNT_W'(DEPTH)) | (w_pop & ~w_q_empty);
  assign w_bypass = BYPASS & w_q_empty & w_pop & w_push;

  // Next PC, queue controls and ID register contents.
  always_comb begin
    w_pc_nxt       = r_pc;
    w_id_valid_nxt = r_id_valid;
    w_id_inst_nxt  = r_id_inst;
    w_id_pc4_nxt   = r_id_pc4;
    w_q_push       = 1'b0;
    w_q_pop        = 1'b0;
    w_q_flush      = 1'b0;
    if (w_cause != CAUSE_NONE) begin
      w_pc_nxt       = w_redir_tgt;
      w_q_flush      = 1'b1;
      w_id_valid_nxt = 1'b0;
      w_id_inst_nxt  = NOP;
      w_id_pc4_nxt   = '0;
    end else begin
      if (w_push) begin
        w_pc_nxt = w_pc4;
        w_q_push = ~w_bypass;
      end
      if (w_pop) begin
        if (!w_q_empty) begin
          w_q_pop        = 1'b1;
          w_id_valid_nxt = 1'b1;
          w_id_inst_nxt  = w_q_rdata[QW-1:XLEN];
          w_id_pc4_nxt   = w_q_rdata[XLEN-1:0];
        end else if (w_bypass) begin
          w_id_valid_nxt = 1'b1;
          w_id_inst_nxt  = bus.if_inst;
          w_id_pc4_nxt   = w_pc4;
        end else begin
          w_id_valid_nxt = 1'b0;
          w_id_inst_nxt  = NOP;
        end
      end
    end
  end

  // PC and ID registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_id_valid <= 1'b0;
      r_id_inst  <= NOP;
      r_id_pc4   <= '0;
    end else begin
      r_pc       <= w_pc_nxt;
      r_id_valid <= w_id_valid_nxt;
      r_id_inst  <= w_id_inst_nxt;
      r_id_pc4   <= w_id_pc4_nxt;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .W     (QW)
  ) u_fetch_queue (
    .clk     (clk),
    .reset   (reset),
    .i_flush (w_q_flush),
    .i_push  (w_q_push),
    .i_pop   (w_q_pop),
    .i_wdata ({bus.if_inst, w_pc4}),
    .o_rdata (w_q_rdata),
    .o_count (w_q_count),
    .o_empty (w_q_empty),
    .o_full  (w_q_full)
  );

  assign bus.if_pc    = r_pc;
  assign bus.kernel   = w_kernel;
  assign bus.id_valid = r_id_valid;
  assign bus.id_inst  = r_id_inst;
  assign bus.id_pc4   = r_id_pc4;
  assign bus.fq_count = w_q_count;

  // Occupancy already encodes fullness; the flag is kept for observability.
  logic w_unused;
  assign w_unused = w_q_full;

endmodule
